// File: rtl/gear_n16_r2_p4_err_corr.sv
// ---------------------------------------------------------------------------
// gear_n16_r2_p4_err_corr
//
// Iterative error detection / correction stage for the 16-bit GeAr
// approximate adder with R=2, P=4 (six 6-bit sub-adders, each starting two
// bits above the previous one, every carry-in tied to 0).
//
// A transfer captures the operands and the 17-bit approximate sum into a
// working register W. Sub-adders 1..5 are then examined in order, one per
// cycle. For sub-adder k the true carry into bit 2k is recovered from W and
// the operands. If that carry is 1 and the low four bits of the sub-adder
// all propagate, the approximation dropped a carry: the error flag is set
// and, when enabled by CORR_MASK, 1 is added to the sub-adder's own result
// field.
//
// Parameters
//   CORR_MASK   bit k-1 enables correction of sub-adder k (detection always)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    input transfer request
//   in_ready    block can accept a transfer (IDLE only)
//   in1, in2    16-bit operands
//   approx_res  17-bit approximate sum from the GeAr adder
//   out_valid   result available (DONE)
//   out_ready   consumer accepts the result
//   out_res     corrected 17-bit sum
//   out_err     bit k-1 set = error detected in sub-adder k
// ---------------------------------------------------------------------------
module gear_n16_r2_p4_err_corr #(
  parameter logic [4:0] CORR_MASK = 5'b11111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic [16:0] approx_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] out_res,
  output logic [4:0]  out_err
);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t      state_reg;
  logic [2:0]  k_reg;
  logic [16:0] w_reg;
  // Only operand bits 2..13 take part in any carry/propagate check.
  logic [13:2] a_reg;
  logic [13:2] b_reg;
  logic [4:0]  flags_reg;
  logic        in_ready_reg;
  logic        out_valid_reg;
  logic [16:0] out_res_reg;
  logic [4:0]  out_err_reg;

  logic [13:2] diff;
  logic [4:0]  err_vec;
  logic [16:0] w_fix [1:5];
  logic [16:0] w_next;
  logic [4:0]  flags_next;

  // Operand bits outside the checked window are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{in1[15:14], in1[1:0], in2[15:14], in2[1:0]};

  assign diff = a_reg ^ b_reg;

  // Per sub-adder: error detect and the W value with its field incremented.
  genvar gi;
  generate
    for (gi = 1; gi <= 5; gi++) begin : g_sub
      // W[2k]^a[2k]^b[2k] recovers the carry into bit 2k from the sum bit.
      assign err_vec[gi-1] = (w_reg[2*gi] ^ a_reg[2*gi] ^ b_reg[2*gi])
                             & (&diff[2*gi+3:2*gi]);
      if (gi < 5) begin : g_mid
        // 2-bit field, wraps mod 4; nothing ripples into higher fields.
        assign w_fix[gi] = {w_reg[16:2*gi+6],
                            w_reg[2*gi+5:2*gi+4] + 2'd1,
                            w_reg[2*gi+3:0]};
      end else begin : g_top
        // Top sub-adder owns the carry-out too: 3-bit field, wraps mod 8.
        assign w_fix[gi] = {w_reg[16:14] + 3'd1, w_reg[13:0]};
      end
    end
  endgenerate

  // Select the sub-adder addressed by k.
  always_comb begin
    w_next     = w_reg;
    flags_next = flags_reg;
    for (int i = 1; i <= 5; i++) begin
      if (k_reg == 3'(i)) begin
        flags_next[i-1] = flags_reg[i-1] | err_vec[i-1];
        if (err_vec[i-1] && CORR_MASK[i-1]) begin
          w_next = w_fix[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      k_reg         <= 3'd1;
      w_reg         <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      flags_reg     <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_res_reg   <= '0;
      out_err_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            w_reg        <= approx_res;
            a_reg        <= in1[13:2];
            b_reg        <= in2[13:2];
            flags_reg    <= '0;
            k_reg        <= 3'd1;
            in_ready_reg <= 1'b0;
            state_reg    <= CHECK;
          end
        end
        CHECK: begin
          w_reg     <= w_next;
          flags_reg <= flags_next;
          if (k_reg == 3'd5) begin
            out_res_reg   <= w_next;
            out_err_reg   <= flags_next;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            k_reg <= k_reg + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_res   = out_res_reg;
  assign out_err   = out_err_reg;

endmodule

// File: tb/tb_gear_n16_r2_p4_err_corr.sv
// ---------------------------------------------------------------------------
// tb_gear_n16_r2_p4_err_corr
//
// Directed bench. Two instances share all inputs: dut_full corrects every
// sub-adder, dut_none corrects none (detection only). Expected values are
// hand-derived per vector for both instances.
// ---------------------------------------------------------------------------
module tb_gear_n16_r2_p4_err_corr;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [16:0] approx_res;
  logic        out_ready;

  logic        in_ready_f, out_valid_f;
  logic [16:0] out_res_f;
  logic [4:0]  out_err_f;
  logic        in_ready_n, out_valid_n;
  logic [16:0] out_res_n;
  logic [4:0]  out_err_n;

  int n_checks = 0;
  int n_errors = 0;

  gear_n16_r2_p4_err_corr #(.CORR_MASK(5'b11111)) dut_full (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_f),
    .in1(in1), .in2(in2), .approx_res(approx_res),
    .out_valid(out_valid_f), .out_ready(out_ready),
    .out_res(out_res_f), .out_err(out_err_f)
  );

  gear_n16_r2_p4_err_corr #(.CORR_MASK(5'b00000)) dut_none (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
    .in1(in1), .in2(in2), .approx_res(approx_res),
    .out_valid(out_valid_n), .out_ready(out_ready),
    .out_res(out_res_n), .out_err(out_err_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until out_valid is seen, bounded.
  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!out_valid_f && cnt < 20) begin
      tick();
      cnt++;
    end
  endtask

  task automatic run_txn(input logic [15:0] a, input logic [15:0] b,
                         input logic [16:0] ap,
                         input logic [16:0] er_f, input logic [4:0] ee_f,
                         input logic [16:0] er_n, input logic [4:0] ee_n);
    int cnt;
    in1 = a; in2 = b; approx_res = ap; in_valid = 1'b1; out_ready = 1'b1;
    check("in_ready_idle", 32'(in_ready_f), 32'd1);
    tick();
    in_valid = 1'b0;
    check("in_ready_busy", 32'(in_ready_f), 32'd0);
    wait_valid(cnt);
    check("latency", 32'(cnt), 32'd5);
    check("valid_none", 32'(out_valid_n), 32'd1);
    check("res_full", 32'(out_res_f), 32'(er_f));
    check("err_full", 32'(out_err_f), 32'(ee_f));
    check("res_none", 32'(out_res_n), 32'(er_n));
    check("err_none", 32'(out_err_n), 32'(ee_n));
    $display("txn a=%h b=%h approx=%h -> full res=%h err=%b | none res=%h err=%b",
             a, b, ap, out_res_f, out_err_f, out_res_n, out_err_n);
    tick();
    check("valid_drop", 32'(out_valid_f), 32'd0);
    check("res_hold_idle", 32'(out_res_f), 32'(er_f));
  endtask

  initial begin
    int cnt;
    rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; approx_res = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready_f), 32'd1);
    check("rst_out_valid", 32'(out_valid_f), 32'd0);
    check("rst_out_res", 32'(out_res_f), 32'd0);
    check("rst_out_err", 32'(out_err_f), 32'd0);
    $display("txn reset done");

    // Single dropped carry in sub-adder 1.
    run_txn(16'h003F, 16'h0001, 17'h00000, 17'h00040, 5'b00001, 17'h00000, 5'b00001);
    // Carry chain through every sub-adder; uncorrected W hides errors 3..5.
    run_txn(16'hFFFF, 16'h0001, 17'h0FFC0, 17'h10000, 5'b11111, 17'h0FFC0, 5'b00011);
    // Exact approximation, no errors.
    run_txn(16'h1234, 16'h0101, 17'h01335, 17'h01335, 5'b00000, 17'h01335, 5'b00000);
    // Two dropped carries.
    run_txn(16'h00FF, 16'h0001, 17'h000C0, 17'h00100, 5'b00011, 17'h000C0, 5'b00011);

    // Backpressure: hold the result for 10 cycles while new data waits.
    out_ready = 1'b0;
    in1 = 16'hFFFF; in2 = 16'h0001; approx_res = 17'h0FFC0; in_valid = 1'b1;
    tick();
    in1 = 16'h1234; in2 = 16'h0101; approx_res = 17'h01335;
    wait_valid(cnt);
    check("bp_latency", 32'(cnt), 32'd5);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(out_valid_f), 32'd1);
      check("bp_in_ready", 32'(in_ready_f), 32'd0);
      check("bp_res", 32'(out_res_f), 32'h10000);
      check("bp_err", 32'(out_err_f), 32'b11111);
      tick();
    end
    $display("txn backpressure held res=%h err=%b", out_res_f, out_err_f);
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid_f), 32'd0);
    check("bp_release_ready", 32'(in_ready_f), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_next_accepted", 32'(in_ready_f), 32'd0);
    wait_valid(cnt);
    check("bp_next_latency", 32'(cnt), 32'd5);
    check("bp_next_res", 32'(out_res_f), 32'h01335);
    check("bp_next_err", 32'(out_err_f), 32'd0);
    $display("txn after backpressure res=%h err=%b", out_res_f, out_err_f);
    tick();

    // Reset while examining sub-adder 3.
    in1 = 16'hFFFF; in2 = 16'h0001; approx_res = 17'h0FFC0; in_valid = 1'b1;
    tick();          // accepted, k=1
    in_valid = 1'b0;
    tick();          // k=2
    tick();          // k=3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready_f), 32'd1);
    check("mid_rst_valid", 32'(out_valid_f), 32'd0);
    check("mid_rst_res", 32'(out_res_f), 32'd0);
    check("mid_rst_err", 32'(out_err_f), 32'd0);
    $display("txn reset mid-check");
    run_txn(16'h003F, 16'h0001, 17'h00000, 17'h00040, 5'b00001, 17'h00000, 5'b00001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
